// File: rtl/branch_pkg.sv
// branch_pkg: shared opcode, funct3 and BHT counter definitions
package branch_pkg;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} cnt_t;
  // funct3[0] inverts the base comparison; funct3 01x is not a branch
  function automatic logic f3_legal(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction
  function automatic logic br_taken(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu);
    return f3[2:1] == 2'b00 ? eq ^ f3[0] :
           f3[2:1] == 2'b10 ? lt ^ f3[0] :
           f3[2:1] == 2'b11 ? ltu ^ f3[0] : 1'b0;
  endfunction
endpackage

// File: rtl/bht_2bit.sv
// bht_2bit: bimodal table of 2-bit saturating counters, comb read, saturating write
module bht_2bit
  import branch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);
  cnt_t cnt [2**IDX_W];
  cnt_t cur, nxt;
  assign rd_taken = cnt[rd_idx] == WT || cnt[rd_idx] == ST;
  always_comb begin
    cur = cnt[wr_idx];
    nxt = wr_taken ? (cur == ST ? ST : cnt_t'(cur + 2'd1)) : (cur == SNT ? SNT : cnt_t'(cur - 2'd1));
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N)
      for (int i = 0; i < 2**IDX_W; i++) cnt[i] <= WNT;
    else if (wr_en)
      cnt[wr_idx] <= nxt;
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves EX branches, trains the BHT and issues registered redirects
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int n     = 32,
  parameter int IDX_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [n-1:0]     if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [6:0]       ex_opcode,
  input  logic [2:0]       ex_funct3,
  input  logic [n-1:0]     ex_pc,
  input  logic             ex_pred_taken,
  input  logic [n-1:0]     ex_target,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             br_ltu,
  output logic             redirect_valid,
  output logic [n-1:0]     redirect_pc,
  output logic             flush,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);
  logic live, legal, taken, resolve, mispred;
  // the instruction in EX while a redirect is out is wrong-path
  always_comb begin
    live    = ex_valid && ex_opcode == OP_BRANCH && !redirect_valid;
    legal   = f3_legal(ex_funct3);
    taken   = br_taken(ex_funct3, br_eq, br_lt, br_ltu);
    resolve = live && legal;
    mispred = resolve && taken != ex_pred_taken;
  end
  bht_2bit #(.IDX_W(IDX_W)) u_bht (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_taken (pred_taken),
    .wr_en    (resolve),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_taken (taken)
  );
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      illegal_br     <= 1'b0;
      br_count       <= '0;
      mispred_count  <= '0;
    end else begin
      redirect_valid <= mispred;
      flush          <= mispred;
      illegal_br     <= live && !legal;
      if (resolve) br_count <= br_count + 1'b1;
      if (mispred) begin
        mispred_count <= mispred_count + 1'b1;
        redirect_pc   <= taken ? ex_target : ex_pc + n'(4);
      end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: table-driven directed check of branch_resolve_unit
module tb_branch_resolve_unit;
  import branch_pkg::*;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [6:0] BR = 7'b1100011;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic [31:0] if_pc = '0, ex_pc = '0, ex_target = '0;
  logic        ex_valid = 1'b0, ex_pred_taken = 1'b0, br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
  logic [6:0]  ex_opcode = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        pred_taken, redirect_valid, flush, illegal_br;
  logic [31:0] redirect_pc, br_count, mispred_count;
  int          nvec = 0, nerr = 0;
  typedef struct {
    logic v; logic [6:0] op; logic [2:0] f3; logic [31:0] pc, tgt, ifpc;
    logic pr, eq, lt, ltu, pre, rv; logic [31:0] rpc; logic ill; int br, mis; logic post;
  } vec_t;
  vec_t tv [21];
  always #5 CLK = ~CLK;
  branch_resolve_unit dut (
    .CLK(CLK), .RST_N(RST_N), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_pc(ex_pc),
    .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .illegal_br(illegal_br), .br_count(br_count), .mispred_count(mispred_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    ex_valid = t.v; ex_opcode = t.op; ex_funct3 = t.f3; ex_pc = t.pc; ex_target = t.tgt;
    if_pc = t.ifpc; ex_pred_taken = t.pr; br_eq = t.eq; br_lt = t.lt; br_ltu = t.ltu;
  endtask
  initial begin
    tv[0]  = '{H, BR, F3_BEQ,  32'h100, 32'h140, 32'h100, L, H, L, L, L, H, 32'h140, L, 1, 1, H};
    tv[1]  = '{L, BR, F3_BEQ,  32'h100, 32'h000, 32'h100, L, L, L, L, H, L, 32'h140, L, 1, 1, H};
    tv[2]  = '{H, BR, F3_BEQ,  32'h100, 32'h140, 32'h100, H, H, L, L, H, L, 32'h140, L, 2, 1, H};
    tv[3]  = '{H, BR, F3_BEQ,  32'h100, 32'h140, 32'h100, H, H, L, L, H, L, 32'h140, L, 3, 1, H};
    tv[4]  = '{H, BR, F3_BEQ,  32'h100, 32'h140, 32'h100, H, H, L, L, H, L, 32'h140, L, 4, 1, H};
    tv[5]  = '{H, BR, F3_BEQ,  32'h100, 32'h140, 32'h100, H, L, L, L, H, H, 32'h104, L, 5, 2, H};
    tv[6]  = '{H, BR, F3_BNE,  32'h100, 32'h300, 32'h100, L, L, L, L, H, L, 32'h104, L, 5, 2, H};
    tv[7]  = '{H, BR, F3_BEQ,  32'h100, 32'h140, 32'h100, H, L, L, L, H, H, 32'h104, L, 6, 3, L};
    tv[8]  = '{L, BR, F3_BEQ,  32'h100, 32'h000, 32'h100, L, L, L, L, L, L, 32'h104, L, 6, 3, L};
    tv[9]  = '{H, BR, F3_BGEU, 32'hFFFFFFFC, 32'h10, 32'hFFFFFFFC, H, L, L, H, L, H, 32'h0, L, 7, 4, L};
    tv[10] = '{L, BR, F3_BEQ,  32'h100, 32'h000, 32'h100, L, L, L, L, L, L, 32'h0, L, 7, 4, L};
    tv[11] = '{H, BR, 3'b010,  32'h100, 32'h020, 32'h100, H, H, L, L, L, L, 32'h0, H, 7, 4, L};
    tv[12] = '{H, BR, F3_BLT,  32'h104, 32'h080, 32'h104, L, L, H, L, L, H, 32'h80, L, 8, 5, H};
    tv[13] = '{L, BR, F3_BEQ,  32'h104, 32'h000, 32'h104, L, L, L, L, H, L, 32'h80, L, 8, 5, H};
    tv[14] = '{H, BR, F3_BGE,  32'h108, 32'h090, 32'h108, L, L, H, L, L, L, 32'h80, L, 9, 5, L};
    tv[15] = '{H, BR, F3_BLTU, 32'h108, 32'h044, 32'h108, L, L, L, H, L, H, 32'h44, L, 10, 6, L};
    tv[16] = '{L, BR, F3_BEQ,  32'h108, 32'h000, 32'h108, L, L, L, L, L, L, 32'h44, L, 10, 6, L};
    tv[17] = '{H, 7'b0110011, F3_BEQ, 32'h108, 32'h060, 32'h108, L, H, L, L, L, L, 32'h44, L, 10, 6, L};
    tv[18] = '{H, BR, F3_BNE,  32'h108, 32'h060, 32'h108, L, H, L, L, L, L, 32'h44, L, 11, 6, L};
    tv[19] = '{H, BR, 3'b011,  32'h108, 32'h060, 32'h108, H, L, L, L, L, L, 32'h44, H, 11, 6, L};
    tv[20] = '{H, BR, F3_BGE,  32'h108, 32'h500, 32'h108, L, L, L, L, L, H, 32'h500, L, 12, 7, L};
    if_pc = 32'h100;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    #1;
    check("reset redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("reset flush", {31'd0, flush}, 32'd0);
    check("reset illegal_br", {31'd0, illegal_br}, 32'd0);
    check("reset redirect_pc", redirect_pc, 32'd0);
    check("reset br_count", br_count, 32'd0);
    check("reset mispred_count", mispred_count, 32'd0);
    check("reset pred_taken", {31'd0, pred_taken}, 32'd0);
    for (int i = 0; i < 21; i++) begin
      drive(tv[i]);
      #1;
      check($sformatf("v%0d pred_pre", i), {31'd0, pred_taken}, {31'd0, tv[i].pre});
      @(posedge CLK);
      #1;
      check($sformatf("v%0d redirect_valid", i), {31'd0, redirect_valid}, {31'd0, tv[i].rv});
      check($sformatf("v%0d flush", i), {31'd0, flush}, {31'd0, tv[i].rv});
      check($sformatf("v%0d redirect_pc", i), redirect_pc, tv[i].rpc);
      check($sformatf("v%0d illegal_br", i), {31'd0, illegal_br}, {31'd0, tv[i].ill});
      check($sformatf("v%0d br_count", i), br_count, 32'(tv[i].br));
      check($sformatf("v%0d mispred_count", i), mispred_count, 32'(tv[i].mis));
      check($sformatf("v%0d pred_post", i), {31'd0, pred_taken}, {31'd0, tv[i].post});
    end
    // redirect is out now; drop reset between edges
    ex_valid = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check("async redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("async flush", {31'd0, flush}, 32'd0);
    check("async redirect_pc", redirect_pc, 32'd0);
    check("async br_count", br_count, 32'd0);
    check("async mispred_count", mispred_count, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    if_pc = 32'h104;
    #1;
    check("async bht 0x104 pred", {31'd0, pred_taken}, 32'd0);
    if_pc = 32'h100;
    #1;
    check("async bht 0x100 pred", {31'd0, pred_taken}, 32'd0);
    ex_valid = 1'b1; ex_opcode = BR; ex_funct3 = F3_BEQ; ex_pc = 32'h104; ex_target = 32'h140;
    ex_pred_taken = 1'b0; br_eq = 1'b1; br_lt = 1'b0; br_ltu = 1'b0; if_pc = 32'h104;
    @(posedge CLK);
    #1;
    ex_valid = 1'b0;
    check("post-reset bht weak", {31'd0, pred_taken}, 32'd1);
    check("post-reset redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("post-reset redirect_pc", redirect_pc, 32'h140);
    check("post-reset br_count", br_count, 32'd1);
    check("post-reset mispred_count", mispred_count, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
